apb_bridge: RTL and testbench
=============================

Name: apb_bridge

Overview:
- Single-master APB3 bridge between the core's simple request/response bus and the peripheral APB segment.
- Converts one request at a time into an APB SETUP/ACCESS transfer.
- Decodes the slave select from address bits and drives one PSEL line per slave, including the GPIO port.
- Returns read data and an error flag. Handles decode misses and slaves that never assert PREADY (timeout).

Parameters:
- NSLAVES, 4: number of APB slaves (1..16); SEL_W = clog2(NSLAVES), minimum 1.
- SEL_LSB, 12: lowest address bit of the slave index field.
- TIMEOUT, 255: maximum ACCESS-phase cycles without PREADY before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request (high only in IDLE).
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  read data; 0 on writes and errors.
- rsp_err  out  1  decode miss, PSLVERR or timeout.
- PADDR  out  32  APB address.
- PSEL  out  NSLAVES  one-hot slave select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PRDATA  in  32*NSLAVES  slave read data, flattened; slave i is at [32*i+31:32*i].
- PREADY  in  NSLAVES  per-slave ready (tie high for slaves without wait states).
- PSLVERR  in  NSLAVES  per-slave error (tie low if unused).

Behaviour:
- Reset (asynchronous, PRESETn low): state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0; rsp_valid=0, rsp_rdata=0, rsp_err=0; timeout counter=0; req_ready=1 after reset release.
- Reset mid-transfer aborts immediately; no response is issued for the aborted request.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1. The request is accepted on the edge where req_valid=1 (cycle N).
  - Latch addr, write and wdata into PADDR, PWRITE, PWDATA.
  - Compute idx = req_addr[SEL_LSB +: SEL_W].
  - If idx < NSLAVES, go to SETUP.
  - Otherwise go to RESP with err=1 and rdata=0; no PSEL is asserted. rsp_valid rises at N+1.
- SETUP (cycle N+1): PSEL[idx]=1, PENABLE=0; go to ACCESS unconditionally.
- ACCESS (cycle N+2 onward):
  - PSEL[idx]=1, PENABLE=1; sample PREADY[idx] every cycle.
  - On PREADY[idx]=1: capture rdata = (PWRITE ? 0 : PRDATA slice idx) and err = PSLVERR[idx]; go to RESP.
  - Zero-wait-state latency: request accepted at N, rsp_valid at N+3.
  - Timeout counter clears on entry to SETUP and increments each ACCESS cycle with PREADY low.
  - When TIMEOUT != 0 and the counter reaches TIMEOUT with PREADY still low: go to RESP with err=1, rdata=0.
  - PREADY high in the same cycle the counter reaches TIMEOUT: complete normally (PREADY wins).
- RESP: PSEL=0, PENABLE=0; rsp_valid=1 for exactly one cycle with rsp_rdata/rsp_err valid; go to IDLE.
- Outside RESP: rsp_valid=0; rsp_rdata and rsp_err hold their last values.
- PADDR, PWRITE and PWDATA:
  - Stable from SETUP through the end of ACCESS.
  - Hold their values in IDLE and RESP; they change only on acceptance.
- PSEL is one-hot or zero at all times; PENABLE=1 only together with a PSEL bit.
- req_valid asserted outside IDLE is ignored (req_ready=0); the requester holds it.
- Back-to-back: a request already valid in IDLE is accepted on the first IDLE cycle after RESP, giving a 4-cycle minimum period.
- No response backpressure: the requester must consume rsp_valid the cycle it is asserted.
- All outputs are registered; no combinational path from PREADY to the APB outputs.

Test Plan:
- Write to slave 1, zero-wait: req_write=1, addr=0x0000_1004, wdata=0xA5 at N.
  - N+1: PSEL=4'b0010, PENABLE=0, PADDR=0x1004, PWDATA=0xA5.
  - N+2: PENABLE=1.
  - N+3: rsp_valid=1, err=0, rdata=0.
- Read with 3 wait states: slave 2 PRDATA=0xDEADBEEF, PREADY low for 3 ACCESS cycles.
  - rsp_valid at N+6 with rdata=0xDEADBEEF, err=0.
  - PADDR and PSEL stable throughout.
- Decode miss: NSLAVES=3, addr=0x3000.
  - No PSEL bit asserted.
  - rsp_valid at N+1, err=1, rdata=0.
- Timeout: TIMEOUT=4, PREADY held low.
  - Exactly 4 ACCESS cycles, then PSEL/PENABLE drop.
  - rsp_valid=1 with err=1, rdata=0.
  - Repeat with PREADY rising on the 4th cycle: err=0, normal completion.
- PSLVERR plus back-to-back: slave 0 returns PSLVERR=1 with PREADY=1 → err=1.
  - A second request, held valid, is accepted the cycle after RESP.
  - Second response arrives 4 cycles after the first.
- Reset mid-ACCESS: drop PRESETn during ACCESS.
  - All outputs go to 0 immediately; no rsp_valid.
  - req_ready=1 after release; a new transfer completes normally.

Source files
------------

// File: rtl/apb_bridge_if.sv
// Signal bundle between the core request/response bus, the APB bridge and the APB slaves.
// The master modport is the bridge's view; the slave modport is the surrounding system.
interface apb_bridge_if #(
    parameter int NSLAVES = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [31:0]             req_addr;
    logic [31:0]             req_wdata;
    logic                    rsp_valid;
    logic [31:0]             rsp_rdata;
    logic                    rsp_err;
    logic [31:0]             PADDR;
    logic [NSLAVES-1:0]      PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [31:0]             PWDATA;
    logic [32*NSLAVES-1:0]   PRDATA;
    logic [NSLAVES-1:0]      PREADY;
    logic [NSLAVES-1:0]      PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_bridge.sv
// Single-master APB3 bridge: one core request at a time becomes an APB SETUP/ACCESS
// transfer with address-decoded slave select, decode-miss and ACCESS timeout handling.
module apb_bridge #(
    parameter int NSLAVES = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 255
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    apb_bridge_if.master bus
);
    localparam int SEL_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SEL_W:0]   NSL = NSLAVES[SEL_W:0];
    localparam logic [CNT_W-1:0] TMO = TIMEOUT[CNT_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t               r_state,     w_state_nxt;
    logic [NSLAVES-1:0]   r_psel,      w_psel_nxt;
    logic                 r_penable,   w_penable_nxt;
    logic [31:0]          r_paddr,     w_paddr_nxt;
    logic                 r_pwrite,    w_pwrite_nxt;
    logic [31:0]          r_pwdata,    w_pwdata_nxt;
    logic                 r_req_ready, w_req_ready_nxt;
    logic                 r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0]          r_rsp_rdata, w_rsp_rdata_nxt;
    logic                 r_rsp_err,   w_rsp_err_nxt;
    logic [CNT_W-1:0]     r_cnt,       w_cnt_nxt;

    logic [SEL_W-1:0]     w_idx;
    logic                 w_hit;
    logic [NSLAVES-1:0]   w_dec;
    logic [31:0]          w_sel_rdata;
    logic                 w_sel_ready;
    logic                 w_sel_err;
    logic [CNT_W-1:0]     w_cnt_inc;

    assign w_idx     = bus.req_addr[SEL_LSB +: SEL_W];
    assign w_hit     = ({1'b0, w_idx} < NSL);
    assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    // Slave decode of the incoming address and mux of the selected slave's responses.
    always_comb begin
        w_sel_rdata = 32'd0;
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_dec       = {NSLAVES{1'b0}};
        for (int i = 0; i < NSLAVES; i++) begin
            w_sel_rdata = w_sel_rdata | (bus.PRDATA[32*i +: 32] & {32{r_psel[i]}});
            w_sel_ready = w_sel_ready | (bus.PREADY[i] & r_psel[i]);
            w_sel_err   = w_sel_err | (bus.PSLVERR[i] & r_psel[i]);
            w_dec[i]    = ({1'b0, w_idx} == i[SEL_W:0]);
        end
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        w_state_nxt     = r_state;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_paddr_nxt     = r_paddr;
        w_pwrite_nxt    = r_pwrite;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_cnt_nxt       = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_paddr_nxt  = bus.req_addr;
                    w_pwrite_nxt = bus.req_write;
                    w_pwdata_nxt = bus.req_wdata;
                    if (w_hit) begin
                        w_state_nxt = S_SETUP;
                        w_psel_nxt  = w_dec;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                    end else begin
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = 32'd0;
                        w_rsp_err_nxt   = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP: begin
                w_state_nxt   = S_ACCESS;
                w_penable_nxt = 1'b1;
            end
            S_ACCESS: begin
                // PREADY takes priority over a timeout expiring in the same cycle.
                if (w_sel_ready) begin
                    w_state_nxt     = S_RESP;
                    w_psel_nxt      = {NSLAVES{1'b0}};
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_pwrite ? 32'd0 : w_sel_rdata;
                    w_rsp_err_nxt   = w_sel_err;
                end else if ((TIMEOUT != 0) && (w_cnt_inc == TMO)) begin
                    w_state_nxt     = S_RESP;
                    w_psel_nxt      = {NSLAVES{1'b0}};
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = 32'd0;
                    w_rsp_err_nxt   = 1'b1;
                    w_cnt_nxt       = w_cnt_inc;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_psel_nxt    = {NSLAVES{1'b0}};
                w_penable_nxt = 1'b0;
            end
        endcase
        w_req_ready_nxt = (w_state_nxt == S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= S_IDLE;
            r_psel      <= {NSLAVES{1'b0}};
            r_penable   <= 1'b0;
            r_paddr     <= 32'd0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= 32'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= {CNT_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.PADDR     = r_paddr;
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PWDATA    = r_pwdata;
endmodule

// File: tb/tb_apb_bridge.sv
// Directed bench for apb_bridge with three slaves and a four-cycle ACCESS timeout.
module tb_apb_bridge;
    localparam int NS = 3;

    logic PCLK;
    logic PRESETn;
    int   checks;
    int   failures;

    apb_bridge_if #(.NSLAVES(NS)) bus ();

    apb_bridge #(.NSLAVES(NS), .SEL_LSB(12), .TIMEOUT(4)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        PRESETn       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.PRDATA    = {32'hDEADBEEF, 32'h22222222, 32'h11111111};
        bus.PREADY    = 3'b111;
        bus.PSLVERR   = 3'b000;

        // Reset state
        #3;
        chk("rst_psel",    32'(bus.PSEL), 32'd0);
        chk("rst_penable", 32'(bus.PENABLE), 32'd0);
        chk("rst_paddr",   bus.PADDR, 32'd0);
        chk("rst_pwdata",  bus.PWDATA, 32'd0);
        chk("rst_rspv",    32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata",   bus.rsp_rdata, 32'd0);
        chk("rst_err",     32'(bus.rsp_err), 32'd0);
        tick();
        tick();
        PRESETn = 1'b1;
        tick();
        chk("rst_ready", 32'(bus.req_ready), 32'd1);

        // Write to slave 1, zero wait
        request(1'b1, 32'h0000_1004, 32'h0000_00A5);
        tick();
        bus.req_valid = 1'b0;
        chk("wr_setup_psel",    32'(bus.PSEL), 32'h2);
        chk("wr_setup_penable", 32'(bus.PENABLE), 32'd0);
        chk("wr_setup_paddr",   bus.PADDR, 32'h0000_1004);
        chk("wr_setup_pwdata",  bus.PWDATA, 32'h0000_00A5);
        chk("wr_setup_pwrite",  32'(bus.PWRITE), 32'd1);
        chk("wr_setup_ready",   32'(bus.req_ready), 32'd0);
        tick();
        chk("wr_access_penable", 32'(bus.PENABLE), 32'd1);
        chk("wr_access_psel",    32'(bus.PSEL), 32'h2);
        chk("wr_access_rspv",    32'(bus.rsp_valid), 32'd0);
        tick();
        chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("wr_rsp_err",   32'(bus.rsp_err), 32'd0);
        chk("wr_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("wr_rsp_psel",  32'(bus.PSEL), 32'd0);
        tick();
        chk("wr_idle_rspv",  32'(bus.rsp_valid), 32'd0);
        chk("wr_idle_ready", 32'(bus.req_ready), 32'd1);
        chk("wr_idle_paddr", bus.PADDR, 32'h0000_1004);

        // Read slave 2 with 3 wait states
        bus.PREADY = 3'b011;
        request(1'b0, 32'h0000_2008, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        chk("rd_setup_psel",  32'(bus.PSEL), 32'h4);
        chk("rd_setup_paddr", bus.PADDR, 32'h0000_2008);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rd_wait_psel",    32'(bus.PSEL), 32'h4);
            chk("rd_wait_penable", 32'(bus.PENABLE), 32'd1);
            chk("rd_wait_paddr",   bus.PADDR, 32'h0000_2008);
            chk("rd_wait_rspv",    32'(bus.rsp_valid), 32'd0);
            if (k == 3) bus.PREADY = 3'b111;
        end
        tick();
        chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rd_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        chk("rd_rsp_err",   32'(bus.rsp_err), 32'd0);
        chk("rd_rsp_psel",  32'(bus.PSEL), 32'd0);
        tick();
        chk("rd_idle_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("rd_hold_rdata", bus.rsp_rdata, 32'hDEADBEEF);

        // Decode miss: index 3 with three slaves
        request(1'b0, 32'h0000_3000, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        chk("miss_psel",  32'(bus.PSEL), 32'd0);
        chk("miss_rspv",  32'(bus.rsp_valid), 32'd1);
        chk("miss_err",   32'(bus.rsp_err), 32'd1);
        chk("miss_rdata", bus.rsp_rdata, 32'd0);
        tick();
        chk("miss_idle_rspv",  32'(bus.rsp_valid), 32'd0);
        chk("miss_idle_ready", 32'(bus.req_ready), 32'd1);

        // Timeout: slave 1 never ready
        bus.PREADY = 3'b101;
        request(1'b0, 32'h0000_1010, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        chk("to_setup_psel", 32'(bus.PSEL), 32'h2);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("to_access_penable", 32'(bus.PENABLE), 32'd1);
            chk("to_access_psel",    32'(bus.PSEL), 32'h2);
            chk("to_access_rspv",    32'(bus.rsp_valid), 32'd0);
        end
        tick();
        chk("to_rsp_psel",    32'(bus.PSEL), 32'd0);
        chk("to_rsp_penable", 32'(bus.PENABLE), 32'd0);
        chk("to_rsp_valid",   32'(bus.rsp_valid), 32'd1);
        chk("to_rsp_err",     32'(bus.rsp_err), 32'd1);
        chk("to_rsp_rdata",   bus.rsp_rdata, 32'd0);
        tick();

        // PREADY rising on the 4th ACCESS cycle wins over the timeout
        request(1'b0, 32'h0000_1014, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("tw_access_penable", 32'(bus.PENABLE), 32'd1);
            if (k == 3) bus.PREADY = 3'b111;
        end
        tick();
        chk("tw_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("tw_rsp_err",   32'(bus.rsp_err), 32'd0);
        chk("tw_rsp_rdata", bus.rsp_rdata, 32'h22222222);
        tick();

        // PSLVERR on slave 0 followed by a held back-to-back read of slave 1
        bus.PSLVERR = 3'b001;
        request(1'b1, 32'h0000_0010, 32'h0000_005A);
        tick();
        request(1'b0, 32'h0000_1020, 32'h0);
        chk("b2b_setup_psel",  32'(bus.PSEL), 32'h1);
        chk("b2b_setup_ready", 32'(bus.req_ready), 32'd0);
        tick();
        chk("b2b_access_paddr", bus.PADDR, 32'h0000_0010);
        tick();
        chk("b2b_rsp1_valid", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_rsp1_err",   32'(bus.rsp_err), 32'd1);
        chk("b2b_rsp1_rdata", bus.rsp_rdata, 32'd0);
        chk("b2b_rsp1_paddr", bus.PADDR, 32'h0000_0010);
        bus.PSLVERR = 3'b000;
        tick();
        chk("b2b_idle_ready", 32'(bus.req_ready), 32'd1);
        chk("b2b_idle_rspv",  32'(bus.rsp_valid), 32'd0);
        tick();
        bus.req_valid = 1'b0;
        chk("b2b_setup2_psel",  32'(bus.PSEL), 32'h2);
        chk("b2b_setup2_paddr", bus.PADDR, 32'h0000_1020);
        tick();
        chk("b2b_access2_rspv", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("b2b_rsp2_valid", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_rsp2_err",   32'(bus.rsp_err), 32'd0);
        chk("b2b_rsp2_rdata", bus.rsp_rdata, 32'h22222222);
        tick();

        // Reset in the middle of ACCESS
        bus.PREADY = 3'b011;
        request(1'b1, 32'h0000_2000, 32'h0000_0077);
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("mr_access_penable", 32'(bus.PENABLE), 32'd1);
        PRESETn = 1'b0;
        #1;
        chk("mr_psel",    32'(bus.PSEL), 32'd0);
        chk("mr_penable", 32'(bus.PENABLE), 32'd0);
        chk("mr_paddr",   bus.PADDR, 32'd0);
        chk("mr_pwdata",  bus.PWDATA, 32'd0);
        chk("mr_pwrite",  32'(bus.PWRITE), 32'd0);
        chk("mr_rspv",    32'(bus.rsp_valid), 32'd0);
        chk("mr_rdata",   bus.rsp_rdata, 32'd0);
        tick();
        chk("mr_hold_rspv", 32'(bus.rsp_valid), 32'd0);
        bus.PREADY = 3'b111;
        PRESETn = 1'b1;
        tick();
        chk("mr_rel_ready", 32'(bus.req_ready), 32'd1);
        chk("mr_rel_rspv",  32'(bus.rsp_valid), 32'd0);
        chk("mr_rel_psel",  32'(bus.PSEL), 32'd0);
        request(1'b1, 32'h0000_2004, 32'h0000_0099);
        tick();
        bus.req_valid = 1'b0;
        chk("mr_new_psel",   32'(bus.PSEL), 32'h4);
        chk("mr_new_pwdata", bus.PWDATA, 32'h0000_0099);
        tick();
        tick();
        chk("mr_new_rspv",  32'(bus.rsp_valid), 32'd1);
        chk("mr_new_err",   32'(bus.rsp_err), 32'd0);
        chk("mr_new_rdata", bus.rsp_rdata, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
